// File: rtl/axil_rd_slv_if.sv
// AXI-Lite read channel bundle (AR + R) between one master and one slave.
//   ar_valid/ar_addr/ar_ready : read address handshake
//   r_valid/r_data/r_resp/r_ready : read response handshake
interface axil_rd_slv_if;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_ready;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axil_rd_slv.sv
// AXI-Lite read-only slave in front of a single-cycle-latency backing memory.
// One transaction at a time; a programmable (fixed or LFSR-driven) delay is
// inserted between address acceptance and the memory access.
//   clk_i       : clock, all state on rising edge
//   rst_i       : synchronous active-high reset
//   slv         : AR/R channel (slave modport)
//   mem_en_o    : one-cycle memory read strobe
//   mem_addr_o  : word-aligned memory address (0 when not strobing)
//   mem_rdata_i : memory data, valid the cycle after mem_en_o
module axil_rd_slv #(
    parameter int unsigned LAT_MODE  = 0,
    parameter int unsigned FIX_LAT   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE  = 32'h0800_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    axil_rd_slv_if.slave       slv,
    output logic               mem_en_o,
    output logic [31:0]        mem_addr_o,
    input  logic [31:0]        mem_rdata_i
);

    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;
    localparam logic [1:0]  RespDecErr = 2'b11;
    localparam logic [3:0]  FixLat     = 4'(FIX_LAT);
    // 33-bit window bounds so BASE_ADDR + MEM_SIZE cannot wrap.
    localparam logic [32:0] WinLo      = {1'b0, BASE_ADDR};
    localparam logic [32:0] WinHi      = {1'b0, BASE_ADDR} + {1'b0, MEM_SIZE};

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StDelay = 4'b0010,
        StMem   = 4'b0100,
        StResp  = 4'b1000
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  resp_q, resp_d;

    logic [32:0] ar_addr_ext;
    logic        dec_err;
    logic [1:0]  err_code;
    logic [3:0]  lat_load;
    logic        mem_en;

    // Address classification; DECERR wins over misalignment.
    always_comb begin
        ar_addr_ext = {1'b0, slv.ar_addr};
        dec_err     = (ar_addr_ext < WinLo) || (ar_addr_ext >= WinHi);
        if (dec_err) begin
            err_code = RespDecErr;
        end else if (slv.ar_addr[1:0] != 2'b00) begin
            err_code = RespSlvErr;
        end else begin
            err_code = RespOkay;
        end
    end

    // x^4 + x^3 + 1, maximal length: cycles through 1..15, never zero.
    assign lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    assign lat_load = (LAT_MODE == 0) ? FixLat : lfsr_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        err_d         = err_q;
        data_d        = data_q;
        resp_d        = resp_q;
        slv.ar_ready  = 1'b0;
        slv.r_valid   = 1'b0;
        mem_en        = 1'b0;

        unique case (state_q)
            StIdle: begin
                slv.ar_ready = 1'b1;
                if (slv.ar_valid) begin
                    addr_d  = slv.ar_addr[31:2];
                    err_d   = err_code;
                    cnt_d   = lat_load;
                    state_d = StDelay;
                end
            end
            StDelay: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (err_q != RespOkay) begin
                    // Error responses skip the memory entirely.
                    data_d  = 32'd0;
                    resp_d  = err_q;
                    state_d = StResp;
                end else begin
                    mem_en  = 1'b1;
                    state_d = StMem;
                end
            end
            StMem: begin
                data_d  = mem_rdata_i;
                resp_d  = RespOkay;
                state_d = StResp;
            end
            StResp: begin
                slv.r_valid = 1'b1;
                if (slv.r_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            lfsr_q  <= 4'b1000;
            addr_q  <= '0;
            err_q   <= RespOkay;
            data_q  <= 32'd0;
            resp_q  <= RespOkay;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
        end
    end

    assign slv.r_data  = data_q;
    assign slv.r_resp  = resp_q;
    assign mem_en_o    = mem_en;
    assign mem_addr_o  = mem_en ? {addr_q, 2'b00} : 32'd0;

endmodule

// File: tb/tb_axil_rd_slv.sv
module tb_axil_rd_slv;

    logic        clk;
    logic        rst;
    logic        sel;          // 0: fixed-latency DUT, 1: LFSR-latency DUT
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic        r_ready;

    logic        mem_en0, mem_en1;
    logic [31:0] mem_addr0, mem_addr1;
    logic [31:0] mem_rdata0, mem_rdata1;

    int n_cmp;
    int n_bad;

    axil_rd_slv_if bus0 ();
    axil_rd_slv_if bus1 ();

    assign bus0.ar_valid = ar_valid & ~sel;
    assign bus1.ar_valid = ar_valid & sel;
    assign bus0.ar_addr  = ar_addr;
    assign bus1.ar_addr  = ar_addr;
    assign bus0.r_ready  = r_ready;
    assign bus1.r_ready  = r_ready;

    axil_rd_slv #(
        .LAT_MODE (0),
        .FIX_LAT  (1)
    ) u_dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv         (bus0),
        .mem_en_o    (mem_en0),
        .mem_addr_o  (mem_addr0),
        .mem_rdata_i (mem_rdata0)
    );

    axil_rd_slv #(
        .LAT_MODE (1),
        .FIX_LAT  (1)
    ) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv         (bus1),
        .mem_en_o    (mem_en1),
        .mem_addr_o  (mem_addr1),
        .mem_rdata_i (mem_rdata1)
    );

    // Observed signals of the selected DUT.
    wire        o_ar_ready = sel ? bus1.ar_ready : bus0.ar_ready;
    wire        o_r_valid  = sel ? bus1.r_valid  : bus0.r_valid;
    wire [31:0] o_r_data   = sel ? bus1.r_data   : bus0.r_data;
    wire [1:0]  o_r_resp   = sel ? bus1.r_resp   : bus0.r_resp;
    wire        o_mem_en   = sel ? mem_en1       : mem_en0;
    wire [31:0] o_mem_addr = sel ? mem_addr1     : mem_addr0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0004) return 32'h0000_0413;
        return a ^ 32'hC3C3_3C3C;
    endfunction

    // Backing memories: data only valid the cycle after the strobe.
    always @(posedge clk) begin
        mem_rdata0 <= mem_en0 ? mem_fn(mem_addr0) : 32'hDEAD_BEEF;
        mem_rdata1 <= mem_en1 ? mem_fn(mem_addr1) : 32'hDEAD_BEEF;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One read; exp_lat < 0 means check the LFSR latency window instead.
    task automatic do_read(input string tag, input logic [31:0] addr, input int exp_lat,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input int hold);
        int          cyc;
        int          vcyc;
        int          en_cnt;
        int          en_cyc;
        logic [31:0] en_addr;
        @(negedge clk);
        ar_valid = 1'b1;
        ar_addr  = addr;
        r_ready  = (hold == 0);
        check_eq({tag, ".ar_ready"}, 32'(o_ar_ready), 32'd1);
        cyc     = 0;
        vcyc    = -1;
        en_cnt  = 0;
        en_cyc  = -1;
        en_addr = 32'd0;
        while (vcyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ar_valid = 1'b0;
            if (o_mem_en) begin
                en_cnt++;
                en_cyc  = cyc;
                en_addr = o_mem_addr;
            end
            if (o_r_valid) vcyc = cyc;
        end
        if (vcyc < 0) begin
            check_eq({tag, ".timeout"}, 32'd0, 32'd1);
            r_ready = 1'b0;
            return;
        end
        if (exp_lat >= 0) check_eq({tag, ".lat"}, 32'(vcyc), 32'(exp_lat));
        else check_eq({tag, ".lat_win"}, 32'(vcyc >= 3 && vcyc <= 18), 32'd1);
        check_eq({tag, ".data"}, o_r_data, exp_data);
        check_eq({tag, ".resp"}, 32'(o_r_resp), 32'(exp_resp));
        if (exp_resp == 2'b00) begin
            check_eq({tag, ".en_cnt"}, 32'(en_cnt), 32'd1);
            check_eq({tag, ".en_cyc"}, 32'(en_cyc), 32'(vcyc - 2));
            check_eq({tag, ".en_addr"}, en_addr, {addr[31:2], 2'b00});
        end else begin
            check_eq({tag, ".en_cnt"}, 32'(en_cnt), 32'd0);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, ".hold_valid"}, 32'(o_r_valid), 32'd1);
            check_eq({tag, ".hold_data"}, o_r_data, exp_data);
            check_eq({tag, ".hold_resp"}, 32'(o_r_resp), 32'(exp_resp));
            check_eq({tag, ".hold_arrdy"}, 32'(o_ar_ready), 32'd0);
        end
        r_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, ".post_valid"}, 32'(o_r_valid), 32'd0);
        check_eq({tag, ".post_arrdy"}, 32'(o_ar_ready), 32'd1);
        r_ready = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          seen;
        logic [31:0] a;
        n_cmp    = 0;
        n_bad    = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        ar_valid = 1'b0;
        ar_addr  = 32'd0;
        r_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            check_eq("rst.ar_ready", 32'(o_ar_ready), 32'd1);
            check_eq("rst.r_valid", 32'(o_r_valid), 32'd0);
            check_eq("rst.mem_en", 32'(o_mem_en), 32'd0);
            check_eq("rst.mem_addr", o_mem_addr, 32'd0);
            check_eq("rst.r_data", o_r_data, 32'd0);
            check_eq("rst.r_resp", 32'(o_r_resp), 32'd0);
        end
        sel = 1'b0;

        // Fixed latency L=1: OKAY at cycle 4, errors at cycle 3.
        do_read("okay",     32'h8000_0004, 4, 32'h0000_0413, 2'b00, 0);
        do_read("slverr",   32'h8000_0006, 3, 32'h0000_0000, 2'b10, 0);
        do_read("dec_lo",   32'h7FFF_FFFC, 3, 32'h0000_0000, 2'b11, 0);
        do_read("dec_hi",   32'h8800_0002, 3, 32'h0000_0000, 2'b11, 0);
        do_read("dec_end",  32'h8800_0000, 3, 32'h0000_0000, 2'b11, 0);
        do_read("dec_top",  32'hFFFF_FFFC, 3, 32'h0000_0000, 2'b11, 0);
        do_read("base",     32'h8000_0000, 4, 32'h43C3_3C3C, 2'b00, 0);
        do_read("last",     32'h87FF_FFFC, 4, 32'h443C_C3C0, 2'b00, 0);
        do_read("hold",     32'h8000_0100, 4, 32'h43C3_3D3C, 2'b00, 5);
        do_read("hold_err", 32'h8000_0101, 3, 32'h0000_0000, 2'b10, 5);

        // Reset while a response is pending.
        @(negedge clk);
        ar_valid = 1'b1;
        ar_addr  = 32'h8000_0010;
        r_ready  = 1'b0;
        cyc      = 0;
        seen     = 0;
        while (seen == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ar_valid = 1'b0;
            if (o_r_valid) seen = 1;
        end
        check_eq("rstresp.reach", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstresp.r_valid", 32'(o_r_valid), 32'd0);
        check_eq("rstresp.ar_ready", 32'(o_ar_ready), 32'd1);
        check_eq("rstresp.mem_en", 32'(o_mem_en), 32'd0);
        r_ready = 1'b1;
        seen    = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_r_valid || o_mem_en) seen = 1;
        end
        check_eq("rstresp.no_resp", 32'(seen), 32'd0);
        r_ready = 1'b0;
        do_read("after_rst", 32'h8000_0010, 4, 32'h43C3_3C2C, 2'b00, 0);

        // LFSR latency mode.
        sel = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 32'h8000_0000 | ($urandom & 32'h07FF_FFFC);
            do_read("rand", a, -1, mem_fn(a), 2'b00, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
